// File: rtl/div_seq.sv
// Radix-2 restoring divider for DIV/DIVU. It retires one quotient bit per clock and
// applies sign correction on the completion edge. Results hold in END until start_i drops.
module div_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               div_zero_o,
  output logic               stallreq_o
);

  typedef enum logic [1:0] {FREE, BY_ZERO, ON, DONE} state_t;

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [WIDTH-1:0]   rem, rem_n;
  logic [WIDTH-1:0]   dvd, dvd_n;   // dividend bits shift out, quotient bits shift in
  logic [WIDTH-1:0]   dvs, dvs_n;
  logic               neg_q, neg_q_n, neg_r, neg_r_n;
  logic [2*WIDTH-1:0] result_n;
  logic               ready_n, div_zero_n;
  logic [WIDTH:0]     rem_sh, diff;
  logic [WIDTH-1:0]   q_fix, r_fix;

  assign stallreq_o = start_i && !ready_o && !annul_i;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= FREE;
      cnt        <= '0;
      rem        <= '0;
      dvd        <= '0;
      dvs        <= '0;
      neg_q      <= 1'b0;
      neg_r      <= 1'b0;
      result_o   <= '0;
      ready_o    <= 1'b0;
      div_zero_o <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      rem        <= rem_n;
      dvd        <= dvd_n;
      dvs        <= dvs_n;
      neg_q      <= neg_q_n;
      neg_r      <= neg_r_n;
      result_o   <= result_n;
      ready_o    <= ready_n;
      div_zero_o <= div_zero_n;
    end
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    rem_n      = rem;
    dvd_n      = dvd;
    dvs_n      = dvs;
    neg_q_n    = neg_q;
    neg_r_n    = neg_r;
    result_n   = result_o;
    ready_n    = ready_o;
    div_zero_n = div_zero_o;
    // Remainder is always below the divisor, so one extra bit holds the shifted trial value.
    rem_sh     = {rem, dvd[WIDTH-1]};
    diff       = rem_sh - {1'b0, dvs};
    q_fix      = neg_q ? -dvd : dvd;
    r_fix      = neg_r ? -rem : rem;
    case (state)
      FREE: begin
        if (start_i && !annul_i) begin
          dvd_n   = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
          dvs_n   = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;
          neg_q_n = signed_div_i && (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
          neg_r_n = signed_div_i && opdata1_i[WIDTH-1];
          rem_n   = '0;
          cnt_n   = '0;
          state_n = (opdata2_i == '0) ? BY_ZERO : ON;
        end
      end
      BY_ZERO: begin
        if (annul_i) begin
          state_n = FREE;
        end else begin
          result_n   = '0;
          ready_n    = 1'b1;
          div_zero_n = 1'b1;
          state_n    = DONE;
        end
      end
      ON: begin
        if (annul_i) begin
          cnt_n   = '0;
          state_n = FREE;
        end else if (cnt != CNT_W'(WIDTH)) begin
          if (!diff[WIDTH]) begin
            rem_n = diff[WIDTH-1:0];
            dvd_n = {dvd[WIDTH-2:0], 1'b1};
          end else begin
            rem_n = rem_sh[WIDTH-1:0];
            dvd_n = {dvd[WIDTH-2:0], 1'b0};
          end
          cnt_n = cnt + CNT_W'(1);
        end else begin
          result_n   = {r_fix, q_fix};
          ready_n    = 1'b1;
          div_zero_n = 1'b0;
          state_n    = DONE;
        end
      end
      DONE: begin
        if (annul_i || !start_i) begin
          result_n = '0;
          ready_n  = 1'b0;
          state_n  = FREE;
        end
      end
      default: state_n = FREE;
    endcase
  end

endmodule

// File: tb/tb_div_seq.sv
// Bench for div_seq. It runs a directed vector table, randomized divides checked against an
// arithmetic model, and hand-written annul, reset and protocol sequences.
module tb_div_seq;
  localparam int W = 32;
  // Edges after the accept edge until ready_o is seen (accept edge + 33 = 34 edges).
  localparam int LAT_ON   = 33;
  localparam int LAT_ZERO = 1;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           signed_div_i = 1'b0;
  logic [W-1:0]   opdata1_i = '0;
  logic [W-1:0]   opdata2_i = '0;
  logic           start_i = 1'b0;
  logic           annul_i = 1'b0;
  logic [2*W-1:0] result_o;
  logic           ready_o, div_zero_o, stallreq_o;

  int total = 0;
  int bad   = 0;

  div_seq #(.WIDTH(W), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .signed_div_i(signed_div_i),
    .opdata1_i(opdata1_i), .opdata2_i(opdata2_i),
    .start_i(start_i), .annul_i(annul_i),
    .result_o(result_o), .ready_o(ready_o),
    .div_zero_o(div_zero_o), .stallreq_o(stallreq_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         sgn;
    logic [31:0]  a;
    logic [31:0]  b;
    logic [63:0]  res;
    logic         dz;
  } vec_t;

  vec_t tbl[12];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic void model(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                                output logic [63:0] res, output logic dz);
    longint sa, sb, q, r;
    if (b == 32'd0) begin
      res = '0;
      dz  = 1'b1;
    end else begin
      if (sgn) begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
      end else begin
        sa = longint'({32'd0, a});
        sb = longint'({32'd0, b});
      end
      q   = sa / sb;
      r   = sa % sb;
      res = {r[31:0], q[31:0]};
      dz  = 1'b0;
    end
  endfunction

  // One full handshake: hold start until ready, hold one extra cycle, then release.
  task automatic run_div(input string name, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp_res, input logic exp_dz);
    int n;
    logic stall_ok;
    @(negedge clk);
    signed_div_i = sgn; opdata1_i = a; opdata2_i = b; start_i = 1'b1;
    @(posedge clk);
    #1;
    // Operands are latched at accept, so scrambling them afterwards must not matter.
    opdata1_i = $urandom; opdata2_i = $urandom; signed_div_i = ~sgn;
    n = 0;
    stall_ok = 1'b1;
    while (!ready_o && n < 40) begin
      if (!stallreq_o) stall_ok = 1'b0;
      @(posedge clk);
      #1;
      n++;
    end
    check({name, " latency"}, 64'(n), exp_dz ? 64'(LAT_ZERO) : 64'(LAT_ON));
    check({name, " result"}, result_o, exp_res);
    check({name, " div_zero"}, 64'(div_zero_o), 64'(exp_dz));
    check({name, " stall_wait"}, 64'(stall_ok), 64'(1));
    check({name, " stall_done"}, 64'(stallreq_o), 64'(0));
    @(posedge clk);
    #1;
    check({name, " hold"}, {ready_o, result_o} , {1'b1, exp_res});
    @(negedge clk);
    start_i = 1'b0;
    @(posedge clk);
    #1;
    check({name, " release"}, {ready_o, result_o}, 65'd0);
    check({name, " dz_hold"}, 64'(div_zero_o), 64'(exp_dz));
  endtask

  task automatic watch_idle(input string name);
    logic seen;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (ready_o) seen = 1'b1;
    end
    check({name, " no_ready"}, 64'(seen), 64'(0));
  endtask

  initial begin
    logic [63:0] er;
    logic        ed, sg;
    logic [31:0] ra, rb;
    int n;

    tbl[0]  = '{1'b0, 32'd100,        32'd7,        {32'd2, 32'd14},                1'b0};
    tbl[1]  = '{1'b1, 32'hFFFFFFF9,   32'd2,        {32'hFFFFFFFF, 32'hFFFFFFFD},   1'b0};
    tbl[2]  = '{1'b1, 32'd7,          32'hFFFFFFFE, {32'd1, 32'hFFFFFFFD},          1'b0};
    tbl[3]  = '{1'b0, 32'd5,          32'd0,        64'd0,                          1'b1};
    tbl[4]  = '{1'b0, 32'd9,          32'd3,        {32'd0, 32'd3},                 1'b0};
    tbl[5]  = '{1'b1, 32'h80000000,   32'hFFFFFFFF, {32'h0, 32'h80000000},          1'b0};
    tbl[6]  = '{1'b0, 32'h80000000,   32'hFFFFFFFF, {32'h80000000, 32'h0},          1'b0};
    tbl[7]  = '{1'b0, 32'd0,          32'd5,        64'd0,                          1'b0};
    tbl[8]  = '{1'b0, 32'hFFFFFFFF,   32'h10,       {32'hF, 32'h0FFFFFFF},          1'b0};
    tbl[9]  = '{1'b1, 32'hFFFFFF9C,   32'd7,        {32'hFFFFFFFE, 32'hFFFFFFF2},   1'b0};
    tbl[10] = '{1'b1, 32'd5,          32'd0,        64'd0,                          1'b1};
    tbl[11] = '{1'b1, 32'hFFFFFFF9,   32'hFFFFFFFE, {32'hFFFFFFFF, 32'd3},          1'b0};

    repeat (2) @(posedge clk);
    #1;
    check("reset outputs", {ready_o, div_zero_o, stallreq_o, result_o}, 67'd0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 12; i++)
      run_div($sformatf("vec%0d", i), tbl[i].sgn, tbl[i].a, tbl[i].b, tbl[i].res, tbl[i].dz);

    for (int i = 0; i < 24; i++) begin
      sg = 1'($urandom_range(0, 1));
      ra = $urandom;
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1, 2:    rb = 32'($urandom_range(1, 15));
        3:       rb = -32'($urandom_range(1, 15));
        default: rb = $urandom;
      endcase
      if (i % 5 == 0) ra = ra >> $urandom_range(0, 31);
      model(sg, ra, rb, er, ed);
      run_div($sformatf("rand%0d", i), sg, ra, rb, er, ed);
    end

    // Annul during iteration 10 of DIV 1000/3.
    @(negedge clk);
    signed_div_i = 1'b1; opdata1_i = 32'd1000; opdata2_i = 32'd3; start_i = 1'b1;
    @(posedge clk);
    repeat (9) @(posedge clk);
    @(negedge clk);
    annul_i = 1'b1;
    #1;
    check("annul stall", 64'(stallreq_o), 64'(0));
    @(posedge clk);
    @(negedge clk);
    annul_i = 1'b0; start_i = 1'b0;
    watch_idle("annul");
    run_div("after_annul", 1'b0, 32'hFFFFFFFF, 32'h10, {32'hF, 32'h0FFFFFFF}, 1'b0);

    // Simultaneous start and annul in FREE is ignored.
    @(negedge clk);
    signed_div_i = 1'b0; opdata1_i = 32'd50; opdata2_i = 32'd5; start_i = 1'b1; annul_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0; annul_i = 1'b0;
    watch_idle("start_annul");

    // start_i dropped mid-divide: the divide finishes, then returns to FREE.
    @(negedge clk);
    signed_div_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1;
    @(posedge clk);
    #1;
    n = 0;
    while (!ready_o && n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (n == 5) start_i = 1'b0;
    end
    check("drop latency", 64'(n), 64'(LAT_ON));
    check("drop result", result_o, {32'd2, 32'd14});
    @(posedge clk);
    #1;
    check("drop release", {ready_o, result_o}, 65'd0);

    // Async reset mid-ON clears state, including a held div_zero flag.
    run_div("pre_reset_zero", 1'b0, 32'd5, 32'd0, 64'd0, 1'b1);
    @(negedge clk);
    signed_div_i = 1'b0; opdata1_i = 32'd12; opdata2_i = 32'd4; start_i = 1'b1;
    @(posedge clk);
    repeat (20) @(posedge clk);
    #2;
    rst = 1'b0;
    start_i = 1'b0;
    #1;
    check("async reset", {ready_o, div_zero_o, result_o}, 66'd0);
    @(negedge clk);
    rst = 1'b1;
    run_div("after_reset", 1'b0, 32'd12, 32'd4, {32'd0, 32'd3}, 1'b0);

    // Async reset while a result is held in END.
    @(negedge clk);
    signed_div_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1;
    n = 0;
    while (!ready_o && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("end_hold result", result_o, {32'd2, 32'd14});
    #2;
    rst = 1'b0;
    #1;
    check("end reset", {ready_o, result_o}, 65'd0);
    start_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
